uvmt_cv32e40x_pma_obi_tracker: RTL and testbench

Downstream consumer of the PMA model's per-address verdict (pma_status_t) in the assertion environment. It captures the verdict at the OBI address-phase handshake and queues it per outstanding transaction. At response time it presents the verdict belonging to the responding transaction, so response-phase assertions can check it. It also flags OBI/PMA protocol violations with sticky error bits; one instance is used per bus, instruction side and data side.

---
 rtl/uvmt_cv32e40x_pkg.sv | 27 ++
 rtl/uvmt_cv32e40x_pma_trk_fifo.sv | 74 +++++++
 rtl/uvmt_cv32e40x_pma_obi_tracker.sv | 158 +++++++++++++++
 tb/tb_uvmt_cv32e40x_pma_obi_tracker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uvmt_cv32e40x_pkg.sv
// Shared types for the PMA verdict tracker: the PMA verdict and the queued per-transaction entry.
// UVMT_PMA_TRK_LATENCY_EN adds an 8-bit age field to each entry.
package uvmt_cv32e40x_pkg;

  localparam int         PMA_TRK_MAX_DEPTH = 4;
  localparam logic [7:0] PMA_TRK_AGE_MAX   = 8'hFF;

  typedef struct packed {
    logic allow;
    logic main;
    logic bufferable;
    logic override_dm;
  } pma_status_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        allow;
    logic        main;
    logic        bufferable;
    logic        override_dm;
`ifdef UVMT_PMA_TRK_LATENCY_EN
    logic [7:0]  age;
`endif
  } pma_trk_entry_t;

endpackage

// File: rtl/uvmt_cv32e40x_pma_trk_fifo.sv
// Circular DEPTH-entry FIFO of tracker entries; a push at full is accepted only alongside a pop.
// Storage is never reset, only pointers and count.
module uvmt_cv32e40x_pma_trk_fifo
  import uvmt_cv32e40x_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  logic           pop_i,
  input  pma_trk_entry_t wdata_i,
  output pma_trk_entry_t rdata_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [2:0]     count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pma_trk_entry_t   mem_q [DEPTH];
  pma_trk_entry_t   mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == 3'(DEPTH));
  assign empty_o = (count_q == 3'd0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pop is resolved first so a push at full finds the freed slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_pop) rd_ptr_d = ptr_next(rd_ptr_q);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uvmt_cv32e40x_pma_obi_tracker.sv
// Captures the PMA verdict at each OBI grant, presents it with the matching response, and
// raises sticky protocol error flags. UVMT_PMA_TRK_LATENCY_EN adds age/latency tracking.
module uvmt_cv32e40x_pma_obi_tracker
  import uvmt_cv32e40x_pkg::*;
#(
  parameter int DEPTH         = 2,
  parameter bit IS_INSTR_SIDE = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           obi_req_i,
  input  logic           obi_gnt_i,
  input  logic [31:0]    obi_addr_i,
  input  logic           obi_we_i,
  input  logic           obi_rvalid_i,
  input  logic           obi_err_i,
  input  pma_status_t    pma_status_i,
  output logic           rsp_valid_o,
  output pma_trk_entry_t rsp_entry_o,
  output logic [2:0]     outstanding_o,
  output logic           err_denied_on_bus_o,
  output logic           err_overflow_o,
  output logic           err_underflow_o,
  output logic           err_bufferable_read_o,
  output logic           err_bus_error_o
`ifdef UVMT_PMA_TRK_LATENCY_EN
  ,
  output logic [7:0]     max_latency_o,
  output logic           err_timeout_o
`endif
);

  if (DEPTH < 1 || DEPTH > PMA_TRK_MAX_DEPTH) begin : g_bad_depth
    $error("uvmt_cv32e40x_pma_obi_tracker: DEPTH must be 1..4");
  end

  logic           push, pop, cap_we;
  logic           full, empty;
  logic [2:0]     count;
  pma_trk_entry_t entry_in, head;
  logic           denied_q, denied_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic           bufrd_q, bufrd_d, buserr_q, buserr_d;

  assign push   = obi_req_i && obi_gnt_i;
  assign pop    = obi_rvalid_i && !empty;
  assign cap_we = IS_INSTR_SIDE ? 1'b0 : obi_we_i;

  always_comb begin
    entry_in             = '0;
    entry_in.addr        = obi_addr_i;
    entry_in.we          = cap_we;
    entry_in.allow       = pma_status_i.allow;
    entry_in.main        = pma_status_i.main;
    entry_in.bufferable  = pma_status_i.bufferable;
    entry_in.override_dm = pma_status_i.override_dm;
  end

  uvmt_cv32e40x_pma_trk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (entry_in),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign rsp_valid_o   = pop;
  assign outstanding_o = count;

  // A response in the same cycle as a grant into an empty queue is an underflow too.
  always_comb begin
    denied_d    = denied_q    | (push && !pma_status_i.allow);
    overflow_d  = overflow_q  | (push && full && !pop);
    underflow_d = underflow_q | (obi_rvalid_i && empty);
    bufrd_d     = bufrd_q     | (push && pma_status_i.bufferable && !cap_we);
    buserr_d    = buserr_q    | (pop && obi_err_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      denied_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      bufrd_q     <= 1'b0;
      buserr_q    <= 1'b0;
    end else begin
      denied_q    <= denied_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      bufrd_q     <= bufrd_d;
      buserr_q    <= buserr_d;
    end
  end

  assign err_denied_on_bus_o   = denied_q;
  assign err_overflow_o        = overflow_q;
  assign err_underflow_o       = underflow_q;
  assign err_bufferable_read_o = bufrd_q;
  assign err_bus_error_o       = buserr_q;

`ifdef UVMT_PMA_TRK_LATENCY_EN
  // Ages are kept by queue position (index 0 = head) and shift down on every pop.
  logic [7:0] age_q [DEPTH];
  logic [7:0] age_d [DEPTH];
  logic [7:0] shifted;
  logic [7:0] max_lat_q, max_lat_d;
  logic       timeout_q, timeout_d;
  logic [2:0] cnt_mid;
  logic       push_acc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == PMA_TRK_AGE_MAX) ? PMA_TRK_AGE_MAX : v + 8'd1;
  endfunction

  assign cnt_mid  = count - {2'b00, pop};
  assign push_acc = push && (!full || pop);

  always_comb begin
    shifted   = 8'd0;
    max_lat_d = max_lat_q;
    timeout_d = timeout_q;
    for (int i = 0; i < DEPTH; i++) begin
      shifted  = pop ? ((i + 1 < DEPTH) ? age_q[(i + 1) % DEPTH] : 8'd0) : age_q[i];
      age_d[i] = (3'(i) < cnt_mid) ? sat_inc(shifted) : 8'd0;
      if (push_acc && 3'(i) == cnt_mid) age_d[i] = 8'd0;
      if (3'(i) < count && age_q[i] == PMA_TRK_AGE_MAX) timeout_d = 1'b1;
    end
    // Latency counts the grant cycle, so the head age is reported one higher.
    if (pop && sat_inc(age_q[0]) > max_lat_q) max_lat_d = sat_inc(age_q[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= 8'd0;
      max_lat_q <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      age_q     <= age_d;
      max_lat_q <= max_lat_d;
      timeout_q <= timeout_d;
    end
  end

  assign max_latency_o = max_lat_q;
  assign err_timeout_o = timeout_q;

  always_comb begin
    rsp_entry_o     = head;
    rsp_entry_o.age = age_q[0];
  end
`else
  assign rsp_entry_o = head;
`endif

endmodule

// File: tb/tb_uvmt_cv32e40x_pma_obi_tracker.sv
// Directed self-checking bench for the PMA OBI tracker (DEPTH=2, data side).
// Latency checks are compiled in with UVMT_PMA_TRK_LATENCY_EN.
module tb_uvmt_cv32e40x_pma_obi_tracker;
  import uvmt_cv32e40x_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           obi_req_i, obi_gnt_i, obi_we_i, obi_rvalid_i, obi_err_i;
  logic [31:0]    obi_addr_i;
  pma_status_t    pma_status_i;
  logic           rsp_valid_o;
  pma_trk_entry_t rsp_entry_o;
  logic [2:0]     outstanding_o;
  logic           err_denied_on_bus_o, err_overflow_o, err_underflow_o;
  logic           err_bufferable_read_o, err_bus_error_o;
`ifdef UVMT_PMA_TRK_LATENCY_EN
  logic [7:0]     max_latency_o;
  logic           err_timeout_o;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  uvmt_cv32e40x_pma_obi_tracker #(.DEPTH(2), .IS_INSTR_SIDE(1'b0)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .obi_req_i             (obi_req_i),
    .obi_gnt_i             (obi_gnt_i),
    .obi_addr_i            (obi_addr_i),
    .obi_we_i              (obi_we_i),
    .obi_rvalid_i          (obi_rvalid_i),
    .obi_err_i             (obi_err_i),
    .pma_status_i          (pma_status_i),
    .rsp_valid_o           (rsp_valid_o),
    .rsp_entry_o           (rsp_entry_o),
    .outstanding_o         (outstanding_o),
    .err_denied_on_bus_o   (err_denied_on_bus_o),
    .err_overflow_o        (err_overflow_o),
    .err_underflow_o       (err_underflow_o),
    .err_bufferable_read_o (err_bufferable_read_o),
    .err_bus_error_o       (err_bus_error_o)
`ifdef UVMT_PMA_TRK_LATENCY_EN
    ,
    .max_latency_o         (max_latency_o),
    .err_timeout_o         (err_timeout_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sets one cycle's bus inputs; hs = request granted in this cycle.
  task automatic drive(input logic hs, input logic [31:0] a, input logic w, input logic al,
                       input logic bf, input logic rv, input logic er);
    obi_req_i               = hs;
    obi_gnt_i               = hs;
    obi_addr_i              = a;
    obi_we_i                = w;
    pma_status_i.allow      = al;
    pma_status_i.main       = 1'b1;
    pma_status_i.bufferable = bf;
    pma_status_i.override_dm = 1'b0;
    obi_rvalid_i            = rv;
    obi_err_i               = er;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] errs;
    do_reset();
    idle();
    errs = {err_denied_on_bus_o, err_overflow_o, err_underflow_o, err_bufferable_read_o, err_bus_error_o};
    total++; if (outstanding_o !== 3'd0) $display("FAIL reset_outstanding got %0d want 0", outstanding_o); else pass_cnt++;
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); else pass_cnt++;
    total++; if (errs !== 5'b0) $display("FAIL reset_errs got %b want 00000", errs); else pass_cnt++;
  endtask

  task automatic test_single_read();
    logic [4:0] errs;
    drive(1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    total++; if (outstanding_o !== 3'd1) $display("FAIL single_out1 got %0d want 1", outstanding_o); else pass_cnt++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (rsp_valid_o !== 1'b1) $display("FAIL single_rsp_valid got %b want 1", rsp_valid_o); else pass_cnt++;
    total++; if (rsp_entry_o.addr !== 32'h0000_1000) $display("FAIL single_addr got %h want 00001000", rsp_entry_o.addr); else pass_cnt++;
    total++; if (rsp_entry_o.we !== 1'b0 || rsp_entry_o.allow !== 1'b1 || rsp_entry_o.main !== 1'b1)
      $display("FAIL single_fields got we=%b allow=%b main=%b want 0 1 1", rsp_entry_o.we, rsp_entry_o.allow, rsp_entry_o.main);
    else pass_cnt++;
    tick();
    idle();
    errs = {err_denied_on_bus_o, err_overflow_o, err_underflow_o, err_bufferable_read_o, err_bus_error_o};
    total++; if (outstanding_o !== 3'd0) $display("FAIL single_out0 got %0d want 0", outstanding_o); else pass_cnt++;
    total++; if (errs !== 5'b0) $display("FAIL single_errs got %b want 00000", errs); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hC0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (outstanding_o !== 3'd2) $display("FAIL b2b_full got %0d want 2", outstanding_o); else pass_cnt++;
    total++; if (rsp_entry_o.addr !== 32'hA0) $display("FAIL b2b_rsp0 got %h want a0", rsp_entry_o.addr); else pass_cnt++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (outstanding_o !== 3'd2) $display("FAIL b2b_overlap got %0d want 2", outstanding_o); else pass_cnt++;
    total++; if (rsp_entry_o.addr !== 32'hB0 || rsp_entry_o.we !== 1'b1)
      $display("FAIL b2b_rsp1 got %h we=%b want b0 we=1", rsp_entry_o.addr, rsp_entry_o.we);
    else pass_cnt++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (rsp_entry_o.addr !== 32'hC0 || rsp_valid_o !== 1'b1)
      $display("FAIL b2b_rsp2 got %h valid=%b want c0 valid=1", rsp_entry_o.addr, rsp_valid_o);
    else pass_cnt++;
    tick();
    idle();
    total++; if (outstanding_o !== 3'd0) $display("FAIL b2b_drain got %0d want 0", outstanding_o); else pass_cnt++;
    total++; if (err_overflow_o !== 1'b0 || err_underflow_o !== 1'b0)
      $display("FAIL b2b_errs got ovf=%b udf=%b want 0 0", err_overflow_o, err_underflow_o);
    else pass_cnt++;
  endtask

  task automatic test_overflow_underflow();
    drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (err_overflow_o !== 1'b0) $display("FAIL ovf_early got %b want 0", err_overflow_o); else pass_cnt++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (err_overflow_o !== 1'b1) $display("FAIL ovf_flag got %b want 1", err_overflow_o); else pass_cnt++;
    total++; if (outstanding_o !== 3'd2) $display("FAIL ovf_count got %0d want 2", outstanding_o); else pass_cnt++;
    total++; if (rsp_entry_o.addr !== 32'h10) $display("FAIL ovf_rsp0 got %h want 10", rsp_entry_o.addr); else pass_cnt++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (rsp_entry_o.addr !== 32'h20) $display("FAIL ovf_rsp1 got %h want 20", rsp_entry_o.addr); else pass_cnt++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL udf_rsp_valid got %b want 0", rsp_valid_o); else pass_cnt++;
    total++; if (err_underflow_o !== 1'b0) $display("FAIL udf_early got %b want 0", err_underflow_o); else pass_cnt++;
    tick();
    idle();
    total++; if (err_underflow_o !== 1'b1) $display("FAIL udf_flag got %b want 1", err_underflow_o); else pass_cnt++;
    total++; if (outstanding_o !== 3'd0) $display("FAIL udf_count got %0d want 0", outstanding_o); else pass_cnt++;
    do_reset();
    idle();
    total++; if (err_underflow_o !== 1'b0 || err_overflow_o !== 1'b0)
      $display("FAIL udf_reset got udf=%b ovf=%b want 0 0", err_underflow_o, err_overflow_o);
    else pass_cnt++;
    total++; if (outstanding_o !== 3'd0) $display("FAIL udf_reset_count got %0d want 0", outstanding_o); else pass_cnt++;
  endtask

  task automatic test_grant_with_rvalid_empty();
    drive(1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL gr_rsp_valid got %b want 0", rsp_valid_o); else pass_cnt++;
    tick();
    idle();
    total++; if (err_underflow_o !== 1'b1) $display("FAIL gr_udf got %b want 1", err_underflow_o); else pass_cnt++;
    total++; if (outstanding_o !== 3'd1) $display("FAIL gr_accepted got %0d want 1", outstanding_o); else pass_cnt++;
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL late_rsp_valid got %b want 0", rsp_valid_o); else pass_cnt++;
    tick();
    idle();
    total++; if (err_underflow_o !== 1'b1) $display("FAIL late_udf got %b want 1", err_underflow_o); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_pma_errors();
    drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    total++; if (err_denied_on_bus_o !== 1'b1) $display("FAIL denied got %b want 1", err_denied_on_bus_o); else pass_cnt++;
    total++; if (err_bufferable_read_o !== 1'b0) $display("FAIL buf_write got %b want 0", err_bufferable_read_o); else pass_cnt++;
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (err_bufferable_read_o !== 1'b1) $display("FAIL buf_read got %b want 1", err_bufferable_read_o); else pass_cnt++;
    total++; if (rsp_entry_o.addr !== 32'h200 || rsp_entry_o.allow !== 1'b0)
      $display("FAIL denied_entry got %h allow=%b want 200 allow=0", rsp_entry_o.addr, rsp_entry_o.allow);
    else pass_cnt++;
    total++; if (err_bus_error_o !== 1'b0) $display("FAIL buserr_early got %b want 0", err_bus_error_o); else pass_cnt++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    total++; if (rsp_entry_o.bufferable !== 1'b1 || rsp_entry_o.addr !== 32'h300)
      $display("FAIL buf_entry got %h buf=%b want 300 buf=1", rsp_entry_o.addr, rsp_entry_o.bufferable);
    else pass_cnt++;
    tick();
    idle();
    total++; if (err_bus_error_o !== 1'b1) $display("FAIL buserr got %b want 1", err_bus_error_o); else pass_cnt++;
    tick();
    total++; if (err_denied_on_bus_o !== 1'b1) $display("FAIL denied_sticky got %b want 1", err_denied_on_bus_o); else pass_cnt++;
    do_reset();
  endtask

`ifdef UVMT_PMA_TRK_LATENCY_EN
  task automatic test_latency();
    drive(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    repeat (4) tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    total++; if (max_latency_o !== 8'd5) $display("FAIL max_latency got %0d want 5", max_latency_o); else pass_cnt++;
    drive(1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    repeat (100) tick();
    total++; if (err_timeout_o !== 1'b0) $display("FAIL timeout_early got %b want 0", err_timeout_o); else pass_cnt++;
    repeat (160) tick();
    total++; if (err_timeout_o !== 1'b1) $display("FAIL timeout got %b want 1", err_timeout_o); else pass_cnt++;
    do_reset();
    idle();
    total++; if (err_timeout_o !== 1'b0 || max_latency_o !== 8'd0)
      $display("FAIL lat_reset got to=%b max=%0d want 0 0", err_timeout_o, max_latency_o);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle();
    tick();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_overflow_underflow();
    test_grant_with_rvalid_empty();
    test_pma_errors();
`ifdef UVMT_PMA_TRK_LATENCY_EN
    test_latency();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
